// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: memory op codes, access lengths,
// FSM state type and small op-decoding helpers.
package mem_stage_pkg;

    localparam int MEM_OP_W   = 4;
    localparam int REG_ADDR_W = 5;

    localparam logic RST_ENABLE = 1'b1;
    localparam logic TRUE_V     = 1'b1;
    localparam logic FALSE_V    = 1'b0;

    localparam logic [MEM_OP_W-1:0] MEM_NONE = 4'd0;
    localparam logic [MEM_OP_W-1:0] MEM_LB   = 4'd1;
    localparam logic [MEM_OP_W-1:0] MEM_LH   = 4'd2;
    localparam logic [MEM_OP_W-1:0] MEM_LW   = 4'd3;
    localparam logic [MEM_OP_W-1:0] MEM_LBU  = 4'd4;
    localparam logic [MEM_OP_W-1:0] MEM_LHU  = 4'd5;
    localparam logic [MEM_OP_W-1:0] MEM_SB   = 4'd6;
    localparam logic [MEM_OP_W-1:0] MEM_SH   = 4'd7;
    localparam logic [MEM_OP_W-1:0] MEM_SW   = 4'd8;

    // Byte count minus one, as the memory controller expects it.
    localparam logic [1:0] LEN_BYTE = 2'd0;
    localparam logic [1:0] LEN_HALF = 2'd1;
    localparam logic [1:0] LEN_WORD = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } mem_state_t;

    // True for any op that needs a memory access; unknown codes are not.
    function automatic logic is_mem_op(input logic [MEM_OP_W-1:0] op);
        case (op)
            MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU,
            MEM_SB, MEM_SH, MEM_SW: is_mem_op = TRUE_V;
            default:                is_mem_op = FALSE_V;
        endcase
    endfunction

    function automatic logic is_store_op(input logic [MEM_OP_W-1:0] op);
        case (op)
            MEM_SB, MEM_SH, MEM_SW: is_store_op = TRUE_V;
            default:                is_store_op = FALSE_V;
        endcase
    endfunction

    function automatic logic [1:0] op_len(input logic [MEM_OP_W-1:0] op);
        case (op)
            MEM_LB, MEM_LBU, MEM_SB: op_len = LEN_BYTE;
            MEM_LH, MEM_LHU, MEM_SH: op_len = LEN_HALF;
            default:                 op_len = LEN_WORD;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Load data extension: turns the controller's raw (zero-extended) read data
// into the architectural register value for the given load op.
module mem_load_ext
    import mem_stage_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [MEM_OP_W-1:0] i_op,
    input  logic [DATA_W-1:0]   i_raw,
    output logic [DATA_W-1:0]   o_data
);

    // Select sign or zero extension from the op's width and signedness.
    always_comb begin
        o_data = i_raw;
        case (i_op)
            MEM_LB:  o_data = {{(DATA_W-8){i_raw[7]}}, i_raw[7:0]};
            MEM_LH:  o_data = {{(DATA_W-16){i_raw[15]}}, i_raw[15:0]};
            MEM_LBU: o_data = {{(DATA_W-8){1'b0}}, i_raw[7:0]};
            MEM_LHU: o_data = {{(DATA_W-16){1'b0}}, i_raw[15:0]};
            default: o_data = i_raw;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: passes ALU results through to MEM_WB and runs loads/stores
// against the memory controller with a req/gnt/done handshake, stalling the
// front of the pipeline until the access has finished.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic [REG_ADDR_W-1:0] ex_reg_addr,
    input  logic [DATA_W-1:0]     ex_reg_data,
    input  logic                  ex_if_write,
    input  logic [MEM_OP_W-1:0]   ex_mem_op,
    input  logic [ADDR_W-1:0]     ex_mem_addr,
    input  logic [DATA_W-1:0]     ex_store_data,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_W-1:0]     mem_addr_o,
    output logic [DATA_W-1:0]     mem_wdata_o,
    output logic [1:0]            mem_len_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_done_i,
    input  logic [DATA_W-1:0]     mem_rdata_i,
    output logic [REG_ADDR_W-1:0] mem_reg_addr,
    output logic [DATA_W-1:0]     mem_reg_data,
    output logic                  if_write,
    output logic                  stall_req_o
);

    mem_state_t            r_state;
    mem_state_t            w_next_state;
    logic                  r_req;
    logic                  r_we;
    logic [ADDR_W-1:0]     r_addr;
    logic [DATA_W-1:0]     r_wdata;
    logic [1:0]            r_len;
    logic [MEM_OP_W-1:0]   r_op;
    logic [DATA_W-1:0]     r_buf;
    logic [DATA_W-1:0]     w_ext;
    logic [DATA_W-1:0]     w_wdata;
    logic                  w_is_mem;
    logic                  w_rd_nonzero;

    assign w_is_mem     = is_mem_op(ex_mem_op);
    assign w_rd_nonzero = (ex_reg_addr != 5'd0);

    assign mem_req_o   = r_req;
    assign mem_we_o    = r_we;
    assign mem_addr_o  = r_addr;
    assign mem_wdata_o = r_wdata;
    assign mem_len_o   = r_len;

    mem_load_ext #(
        .DATA_W (DATA_W)
    ) u_load_ext (
        .i_op   (r_op),
        .i_raw  (r_buf),
        .o_data (w_ext)
    );

    // Store data with the bytes beyond the access width cleared.
    always_comb begin
        w_wdata = ex_store_data;
        case (ex_mem_op)
            MEM_SB:  w_wdata = {{(DATA_W-8){1'b0}}, ex_store_data[7:0]};
            MEM_SH:  w_wdata = {{(DATA_W-16){1'b0}}, ex_store_data[15:0]};
            default: w_wdata = ex_store_data;
        endcase
    end

    // FSM state register; reset aborts any outstanding access.
    always_ff @(posedge clk_in) begin
        if (rst_in == RST_ENABLE) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Request fields and load buffer, updated on handshake events.
    always_ff @(posedge clk_in) begin
        if (rst_in == RST_ENABLE) begin
            r_req   <= FALSE_V;
            r_we    <= FALSE_V;
            r_addr  <= '0;
            r_wdata <= '0;
            r_len   <= LEN_BYTE;
            r_op    <= MEM_NONE;
            r_buf   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_is_mem) begin
                        r_req   <= TRUE_V;
                        r_we    <= is_store_op(ex_mem_op);
                        r_addr  <= ex_mem_addr;
                        r_wdata <= w_wdata;
                        r_len   <= op_len(ex_mem_op);
                        r_op    <= ex_mem_op;
                    end
                end
                ST_REQ: begin
                    if (mem_gnt_i) begin
                        r_req <= FALSE_V;
                        if (mem_done_i) begin
                            r_buf <= mem_rdata_i;
                        end
                    end
                end
                ST_WAIT: begin
                    if (mem_done_i) begin
                        r_buf <= mem_rdata_i;
                    end
                end
                default: begin
                    r_req <= FALSE_V;
                end
            endcase
        end
    end

    // Next-state and MEM_WB/stall outputs, all zero while reset is asserted.
    always_comb begin
        w_next_state = r_state;
        mem_reg_addr = ex_reg_addr;
        mem_reg_data = ex_reg_data;
        if_write     = FALSE_V;
        stall_req_o  = FALSE_V;
        if (rst_in == RST_ENABLE) begin
            w_next_state = ST_IDLE;
            mem_reg_addr = '0;
            mem_reg_data = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_is_mem) begin
                        stall_req_o  = TRUE_V;
                        w_next_state = ST_REQ;
                    end else begin
                        if_write = ex_if_write && w_rd_nonzero;
                    end
                end
                ST_REQ: begin
                    stall_req_o = TRUE_V;
                    if (mem_gnt_i) begin
                        w_next_state = mem_done_i ? ST_DONE : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    stall_req_o = TRUE_V;
                    if (mem_done_i) begin
                        w_next_state = ST_DONE;
                    end
                end
                ST_DONE: begin
                    w_next_state = ST_IDLE;
                    if (is_store_op(r_op)) begin
                        if_write = FALSE_V;
                    end else begin
                        mem_reg_data = w_ext;
                        if_write     = ex_if_write && w_rd_nonzero;
                    end
                end
                default: begin
                    w_next_state = ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed cases plus randomized op sequences checked
// against a transaction-level model of the MEM stage and its handshake.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic [4:0]  ex_reg_addr = 5'd0;
    logic [31:0] ex_reg_data = 32'd0;
    logic        ex_if_write = 1'b0;
    logic [3:0]  ex_mem_op = 4'd0;
    logic [31:0] ex_mem_addr = 32'd0;
    logic [31:0] ex_store_data = 32'd0;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [1:0]  mem_len_o;
    logic        mem_gnt_i = 1'b0;
    logic        mem_done_i = 1'b0;
    logic [31:0] mem_rdata_i = 32'd0;
    logic [4:0]  mem_reg_addr;
    logic [31:0] mem_reg_data;
    logic        if_write;
    logic        stall_req_o;

    int n_total = 0;
    int n_bad   = 0;

    mem_stage dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .ex_reg_addr   (ex_reg_addr),
        .ex_reg_data   (ex_reg_data),
        .ex_if_write   (ex_if_write),
        .ex_mem_op     (ex_mem_op),
        .ex_mem_addr   (ex_mem_addr),
        .ex_store_data (ex_store_data),
        .mem_req_o     (mem_req_o),
        .mem_we_o      (mem_we_o),
        .mem_addr_o    (mem_addr_o),
        .mem_wdata_o   (mem_wdata_o),
        .mem_len_o     (mem_len_o),
        .mem_gnt_i     (mem_gnt_i),
        .mem_done_i    (mem_done_i),
        .mem_rdata_i   (mem_rdata_i),
        .mem_reg_addr  (mem_reg_addr),
        .mem_reg_data  (mem_reg_data),
        .if_write      (if_write),
        .stall_req_o   (stall_req_o)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // ---- reference model: byte counts and value arithmetic ----
    function automatic int m_bytes(input logic [3:0] op);
        case (op)
            MEM_LB, MEM_LBU, MEM_SB: return 1;
            MEM_LH, MEM_LHU, MEM_SH: return 2;
            default:                 return 4;
        endcase
    endfunction

    function automatic logic [31:0] m_mask(input int bytes);
        if (bytes == 4) return 32'hFFFF_FFFF;
        return (32'd1 << (8 * bytes)) - 32'd1;
    endfunction

    function automatic logic m_is_store(input logic [3:0] op);
        return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
    endfunction

    function automatic logic [31:0] m_load_value(input logic [3:0] op, input logic [31:0] raw);
        logic [31:0] v;
        v = raw & m_mask(m_bytes(op));
        if (op == MEM_LB && v >= 32'd128)   v = v - 32'd256;
        if (op == MEM_LH && v >= 32'd32768) v = v - 32'd65536;
        return v;
    endfunction

    // One non-memory instruction: results must appear in the same cycle.
    task automatic run_none(input logic [3:0] op, input logic [4:0] rd,
                            input logic [31:0] data, input logic wen);
        @(posedge clk_in); #1;
        ex_mem_op = op; ex_reg_addr = rd; ex_reg_data = data; ex_if_write = wen;
        ex_mem_addr = $urandom; ex_store_data = $urandom;
        mem_gnt_i = 1'b0; mem_done_i = 1'b0;
        @(negedge clk_in);
        check("pt_addr",  {27'd0, mem_reg_addr}, {27'd0, rd});
        check("pt_data",  mem_reg_data, data);
        check("pt_wr",    {31'd0, if_write}, {31'd0, wen && (rd != 5'd0)});
        check("pt_stall", {31'd0, stall_req_o}, 32'd0);
        check("pt_req",   {31'd0, mem_req_o}, 32'd0);
    endtask

    // One memory op. gcyc = cycles the request stays up (grant in the last),
    // ddly = cycles from grant to done (0 = same cycle).
    task automatic run_mem(input logic [3:0] op, input logic [31:0] addr,
                           input logic [31:0] sdata, input logic [4:0] rd,
                           input logic wen, input int gcyc, input int ddly,
                           input logic [31:0] raw);
        int          bytes;
        int          done_c;
        logic        st;
        logic [31:0] rd_val;
        bytes  = m_bytes(op);
        st     = m_is_store(op);
        rd_val = raw & m_mask(bytes);
        done_c = gcyc + ddly + 1;

        @(posedge clk_in); #1;
        ex_mem_op = op; ex_mem_addr = addr; ex_store_data = sdata;
        ex_reg_addr = rd; ex_reg_data = $urandom; ex_if_write = wen;
        mem_gnt_i = 1'b0; mem_done_i = 1'b0;
        @(negedge clk_in);
        check("issue_stall", {31'd0, stall_req_o}, 32'd1);
        check("issue_wr",    {31'd0, if_write}, 32'd0);
        check("issue_req",   {31'd0, mem_req_o}, 32'd0);

        for (int c = 1; c <= done_c; c++) begin
            @(posedge clk_in); #1;
            mem_gnt_i   = (c == gcyc);
            mem_done_i  = (c == gcyc + ddly);
            mem_rdata_i = mem_done_i ? rd_val : $urandom;
            @(negedge clk_in);
            if (c <= gcyc) begin
                check("req_on",  {31'd0, mem_req_o}, 32'd1);
                check("req_addr", mem_addr_o, addr);
                check("req_we",  {31'd0, mem_we_o}, {31'd0, st});
                check("req_len", {30'd0, mem_len_o}, bytes - 1);
                if (st) check("req_wdata", mem_wdata_o, sdata & m_mask(bytes));
            end else begin
                check("req_off", {31'd0, mem_req_o}, 32'd0);
            end
            if (c == done_c) begin
                check("done_stall", {31'd0, stall_req_o}, 32'd0);
                check("done_rd",    {27'd0, mem_reg_addr}, {27'd0, rd});
                check("done_wr",    {31'd0, if_write},
                      {31'd0, !st && wen && (rd != 5'd0)});
                if (!st) check("done_data", mem_reg_data, m_load_value(op, raw));
            end else begin
                check("busy_stall", {31'd0, stall_req_o}, 32'd1);
                check("busy_wr",    {31'd0, if_write}, 32'd0);
            end
        end
        mem_gnt_i = 1'b0; mem_done_i = 1'b0;
    endtask

    // Reset while a LW waits for done, then a stray done pulse.
    task automatic run_reset_mid_wait();
        @(posedge clk_in); #1;
        ex_mem_op = MEM_LW; ex_mem_addr = 32'h200; ex_reg_addr = 5'd3; ex_if_write = 1'b1;
        @(posedge clk_in); #1;
        mem_gnt_i = 1'b1;
        @(posedge clk_in); #1;
        mem_gnt_i = 1'b0;
        @(negedge clk_in);
        check("wait_stall", {31'd0, stall_req_o}, 32'd1);
        check("wait_req",   {31'd0, mem_req_o}, 32'd0);
        @(posedge clk_in); #1;
        rst_in = 1'b1; ex_mem_op = MEM_NONE; ex_if_write = 1'b0; ex_reg_addr = 5'd7;
        @(negedge clk_in);
        check("rst_stall", {31'd0, stall_req_o}, 32'd0);
        check("rst_wr",    {31'd0, if_write}, 32'd0);
        check("rst_rd",    {27'd0, mem_reg_addr}, 32'd0);
        @(posedge clk_in); #1;
        rst_in = 1'b0;
        @(negedge clk_in);
        check("post_rst_req",   {31'd0, mem_req_o}, 32'd0);
        check("post_rst_stall", {31'd0, stall_req_o}, 32'd0);
        check("post_rst_wr",    {31'd0, if_write}, 32'd0);
        @(posedge clk_in); #1;
        mem_done_i = 1'b1; mem_rdata_i = 32'hBAD0_BAD0;
        ex_reg_addr = 5'd9; ex_reg_data = 32'h0000_5A5A; ex_if_write = 1'b1;
        @(negedge clk_in);
        check("late_done_stall", {31'd0, stall_req_o}, 32'd0);
        check("late_done_data",  mem_reg_data, 32'h0000_5A5A);
        @(posedge clk_in); #1;
        mem_done_i = 1'b0;
        @(negedge clk_in);
        check("late_after_data",  mem_reg_data, 32'h0000_5A5A);
        check("late_after_wr",    {31'd0, if_write}, 32'd1);
        check("late_after_req",   {31'd0, mem_req_o}, 32'd0);
    endtask

    initial begin
        // Reset state: combinational outputs forced low, request fields cleared.
        ex_reg_addr = 5'd5; ex_reg_data = 32'h1234; ex_if_write = 1'b1;
        @(negedge clk_in);
        check("rst_comb_rd",    {27'd0, mem_reg_addr}, 32'd0);
        check("rst_comb_data",  mem_reg_data, 32'd0);
        check("rst_comb_wr",    {31'd0, if_write}, 32'd0);
        check("rst_comb_stall", {31'd0, stall_req_o}, 32'd0);
        @(negedge clk_in);
        check("rst_req",   {31'd0, mem_req_o}, 32'd0);
        check("rst_we",    {31'd0, mem_we_o}, 32'd0);
        check("rst_addr",  mem_addr_o, 32'd0);
        check("rst_wdata", mem_wdata_o, 32'd0);
        check("rst_len",   {30'd0, mem_len_o}, 32'd0);
        @(posedge clk_in); #1;
        rst_in = 1'b0;

        // Directed cases.
        run_none(MEM_NONE, 5'd5, 32'h1234, 1'b1);
        run_none(MEM_NONE, 5'd0, 32'h1234, 1'b1);
        run_mem(MEM_LB,  32'h100, 32'h0, 5'd4, 1'b1, 2, 3, 32'h80);
        run_mem(MEM_LHU, 32'h104, 32'h0, 5'd6, 1'b1, 1, 1, 32'h8001);
        run_mem(MEM_LW,  32'h108, 32'h0, 5'd8, 1'b1, 3, 2, 32'hDEAD_BEEF);
        run_mem(MEM_SB,  32'h10C, 32'hAABB_CCDD, 5'd2, 1'b1, 1, 2, 32'h0);
        run_mem(MEM_LW,  32'h110, 32'h0, 5'd10, 1'b1, 1, 0, 32'h5);
        run_none(MEM_NONE, 5'd11, 32'h0000_0777, 1'b1);
        run_none(4'd12, 5'd12, 32'hCAFE_0001, 1'b1);
        run_reset_mid_wait();

        // Randomized instruction stream.
        for (int i = 0; i < 60; i++) begin
            logic [3:0] op;
            op = 4'($urandom_range(0, 15));
            if (op >= MEM_LB && op <= MEM_SW)
                run_mem(op, $urandom, $urandom, 5'($urandom_range(0, 31)),
                        1'($urandom_range(0, 1)), $urandom_range(1, 4),
                        $urandom_range(0, 4), $urandom);
            else
                run_none(op, 5'($urandom_range(0, 31)), $urandom,
                         1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM stage of the 5-stage RV32I core, between EX_MEM and MEM_WB.
- Non-memory instructions pass straight through.
- Loads and stores are issued to the memory controller with a request/grant/done handshake. Load data is sign- or zero-extended.
- The pipeline is stalled until the access completes.
- Outputs go directly into the MEM_WB register.

Parameters:
- ADDR_W, 32, memory address width.
- DATA_W, 32, register and data width (RegBus).

Ports:
- clk_in  input  1  clock.
- rst_in  input  1  synchronous active-high reset.
- ex_reg_addr  input  5  destination register from EX_MEM.
- ex_reg_data  input  32  ALU result from EX_MEM.
- ex_if_write  input  1  register write enable from EX_MEM.
- ex_mem_op  input  4  memory op code (MEM_NONE/LB/LH/LW/LBU/LHU/SB/SH/SW).
- ex_mem_addr  input  32  effective address.
- ex_store_data  input  32  rs2 value for stores.
- mem_req_o  output  1  access request to memory controller.
- mem_we_o  output  1  1 = store.
- mem_addr_o  output  32  access address.
- mem_wdata_o  output  32  store data, low bytes valid.
- mem_len_o  output  2  byte count minus 1 (0 = byte, 1 = half, 3 = word).
- mem_gnt_i  input  1  controller accepted the request this cycle.
- mem_done_i  input  1  access complete; mem_rdata_i valid this cycle.
- mem_rdata_i  input  32  read data, zero-extended by the controller.
- mem_reg_addr  output  5  to MEM_WB.
- mem_reg_data  output  32  to MEM_WB.
- if_write  output  1  to MEM_WB.
- stall_req_o  output  1  hold PC/IF_ID/ID_EX/EX_MEM.

Behaviour:
- Clock and reset: clk_in is the single clock. rst_in is synchronous and active-high; a reset is sampled on the rising edge of clk_in.
- Reset: state = IDLE; mem_req_o, mem_we_o, mem_len_o, mem_addr_o, mem_wdata_o = 0; internal load buffer = 0.
  - Combinational outputs during reset: mem_reg_addr = 0, mem_reg_data = 0, if_write = 0, stall_req_o = 0.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE, ex_mem_op == MEM_NONE:
  - Pass-through, combinational, zero-cycle latency: mem_reg_addr = ex_reg_addr, mem_reg_data = ex_reg_data, if_write = ex_if_write && (ex_reg_addr != 0).
  - stall_req_o = 0.
- IDLE, ex_mem_op != MEM_NONE:
  - stall_req_o = 1 combinationally in the same cycle. if_write = 0 (bubble into MEM_WB).
  - Next edge: register mem_addr_o, mem_wdata_o, mem_we_o and mem_len_o from the inputs; set mem_req_o = 1; go to REQ.
- REQ:
  - mem_req_o and all request fields are held stable until mem_gnt_i is sampled high.
  - On that edge: mem_req_o = 0, go to WAIT.
  - If mem_done_i is also high in the same cycle as grant, go directly to DONE and capture data.
  - stall_req_o = 1, if_write = 0.
- WAIT:
  - stall_req_o = 1, if_write = 0.
  - On mem_done_i: capture mem_rdata_i into the load buffer, go to DONE.
  - mem_done_i is ignored in IDLE and REQ, except for the grant+done case above.
- DONE (exactly one cycle):
  - stall_req_o = 0; mem_reg_addr = ex_reg_addr.
  - Loads: mem_reg_data = extended buffer; if_write = ex_if_write && (ex_reg_addr != 0).
  - Stores: if_write = 0.
  - Next edge: go to IDLE. EX_MEM advances on this same edge, so the next instruction is seen in IDLE and no op is reissued.
- Extension:
  - LB/LH sign-extend bit 7/15.
  - LBU/LHU zero-extend.
  - LW is taken as is.
- Store data: SB/SH mask mem_wdata_o to the low 8/16 bits; upper bits = 0.
- Misalignment: not detected; the address is forwarded unchanged.
- Back-to-back memory ops: each one costs at least IDLE→REQ→WAIT/DONE→IDLE, with no overlap.
- Reset mid-operation (REQ/WAIT): abort and return to IDLE with mem_req_o = 0. The controller shares rst_in and aborts too. A late mem_done_i after reset is ignored.
- Unknown op code: treated as MEM_NONE.

Decomposition:
- Shared define file additions:
  - MEM_NONE, MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU, MEM_SB, MEM_SH, MEM_SW (4-bit).
  - MemOpBus width.
  - LEN_BYTE/LEN_HALF/LEN_WORD.
  - Reuses existing RegAddrBus, RegBus, RstEnable, ZeroWorld, True/False.
- Sub-module: mem_load_ext. Combinational: op + 32-bit raw data → extended 32-bit value.

Test Plan:
- Reset mid-WAIT: assert rst_in while a LW is outstanding → next cycle state IDLE, mem_req_o = 0, stall_req_o = 0, if_write = 0; a mem_done_i pulse afterwards has no effect.
- ALU pass-through: ex_reg_addr = 5, ex_reg_data = 0x1234, ex_if_write = 1, op NONE → same cycle mem_reg_addr = 5, mem_reg_data = 0x1234, if_write = 1, stall_req_o = 0. Repeat with rd = 0 → if_write = 0.
- LB sign-extension: LB at address 0x100, grant after 2 cycles, done 3 cycles later with rdata = 0x80 → mem_req_o held for exactly 2 cycles with mem_len_o = 0; the DONE cycle gives mem_reg_data = 0xFFFFFF80, if_write = 1, stall_req_o low only in DONE.
- LHU/LW: LHU with rdata 0x8001 → 0x00008001; LW with rdata 0xDEADBEEF → 0xDEADBEEF.
- SB store: SB with store_data 0xAABBCCDD → mem_we_o = 1, mem_wdata_o = 0x000000DD, mem_len_o = 0; if_write stays 0 throughout.
- Grant and done in the same cycle: LW gets gnt and done together with rdata 0x5 → next cycle is DONE with mem_reg_data = 5; the following cycle is IDLE with no second request issued.
